// File: rtl/blake_src_pkg.sv
// Shared constants and helpers for the Blake source FIFO front end.
package blake_src_pkg;

  // Avalon word addresses
  localparam logic [2:0] ADDR_LO    = 3'd0;
  localparam logic [2:0] ADDR_HI    = 3'd1;
  localparam logic [2:0] ADDR_LO_SW = 3'd2;
  localparam logic [2:0] ADDR_HI_SW = 3'd3;
  localparam logic [2:0] ADDR_STAT  = 3'd4;
  localparam logic [2:0] ADDR_DROP  = 3'd5;
  localparam logic [2:0] ADDR_STAGE = 3'd6;

  // Status register bit positions
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_LEVEL_LSB = 8;

  // Saturation value of the drop counter
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Reverse the byte order of a 32-bit word
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/blake_sync_fifo.sv
// 64-bit synchronous FIFO with flush; head word is read straight from storage.
module blake_sync_fifo
  import blake_src_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [63:0]   wdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic [63:0]   head
);

  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          pop_ok;
  logic          push_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  // Accept a pop only when data exists; a push on full is accepted only if a pop frees the slot.
  // Flush wins over both so the FIFO ends the cycle empty.
  always_comb begin
    pop_ok   = pop && !empty && !flush;
    push_ok  = push && !flush && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Storage, pointers and level registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/blake_src_fifo.sv
// Avalon-MM front end that assembles 64-bit message words and queues them for the Blake core.
module blake_src_fifo
  import blake_src_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  input  logic        chipselect,
  output logic [31:0] readdata,
  output logic        src_ready,
  input  logic        src_read,
  output logic [63:0] din
);

  logic [31:0] staged_low_q, staged_low_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] readdata_q, readdata_d;

  logic        wr_en;
  logic        rd_en;
  logic        push;
  logic        flush;
  logic        drop_evt;
  logic [31:0] hi_word;
  logic [63:0] push_word;
  logic [31:0] stat_word;

  logic        fifo_empty;
  logic        fifo_full;
  logic [AW:0] fifo_level;
  logic [63:0] fifo_head;

  blake_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (src_read),
    .flush   (flush),
    .wdata   (push_word),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level),
    .head    (fifo_head)
  );

  assign src_ready = fifo_empty;
  assign din       = fifo_head;
  assign readdata  = readdata_q;

  // Decode Avalon writes into stage / push / flush and track overflow and drops.
  // A full FIFO is never empty, so a drop happens exactly when no pop is requested.
  always_comb begin
    wr_en        = chipselect && write;
    rd_en        = chipselect && read;
    push         = wr_en && ((address == ADDR_HI) || (address == ADDR_HI_SW));
    flush        = wr_en && (address == ADDR_STAT) && writedata[0];
    hi_word      = (address == ADDR_HI_SW) ? bswap32(writedata) : writedata;
    push_word    = {hi_word, staged_low_q};
    drop_evt     = push && fifo_full && !src_read;

    staged_low_d = staged_low_q;
    if (wr_en && (address == ADDR_LO))    staged_low_d = writedata;
    if (wr_en && (address == ADDR_LO_SW)) staged_low_d = bswap32(writedata);

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_evt) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if (flush) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Read mux; status reflects state before this cycle's write or pop.
  always_comb begin
    stat_word                               = '0;
    stat_word[STAT_EMPTY_BIT]               = fifo_empty;
    stat_word[STAT_FULL_BIT]                = fifo_full;
    stat_word[STAT_OVF_BIT]                 = overflow_q;
    stat_word[STAT_LEVEL_LSB +: AW+1]       = fifo_level;
    readdata_d = '0;
    if (rd_en) begin
      case (address)
        ADDR_STAT:  readdata_d = stat_word;
        ADDR_DROP:  readdata_d = {16'h0000, drop_cnt_q};
        ADDR_STAGE: readdata_d = staged_low_q;
        default:    readdata_d = '0;
      endcase
    end
  end

  // Control and read-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      staged_low_q <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      readdata_q   <= '0;
    end else begin
      staged_low_q <= staged_low_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      readdata_q   <= readdata_d;
    end
  end

endmodule

// File: tb/tb_blake_src_fifo.sv
// Bench for blake_src_fifo: directed scenarios plus random traffic against a queue model.
module tb_blake_src_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [31:0] readdata;
  logic        src_ready;
  logic        src_read;
  logic [63:0] din;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [63:0] mq[$];
  logic [31:0] m_stage;
  logic        m_ovf;
  int          m_drop;

  blake_src_fifo #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .writedata  (writedata),
    .write      (write),
    .read       (read),
    .chipselect (chipselect),
    .readdata   (readdata),
    .src_ready  (src_ready),
    .src_read   (src_read),
    .din        (din)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byte_rev(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_stage = '0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endfunction

  // One bus cycle: drive on the falling edge, update the model, check just after the rising edge.
  task automatic txn(input logic [2:0] a, input logic [31:0] wd, input logic wr,
                     input logic rd, input logic cs, input logic sr);
    int          lvl;
    logic [31:0] exp_rd;
    logic        flush, pop_ok, do_push;
    logic [63:0] word;
    @(negedge clk);
    address = a; writedata = wd; write = wr; read = rd; chipselect = cs; src_read = sr;
    lvl = mq.size();
    case (a)
      3'd4:    exp_rd = {16'h0, 8'(lvl), 5'b0, m_ovf, (lvl == DEPTH), (lvl == 0)};
      3'd5:    exp_rd = 32'(m_drop);
      3'd6:    exp_rd = m_stage;
      default: exp_rd = 32'h0;
    endcase
    flush   = cs && wr && (a == 3'd4) && wd[0];
    pop_ok  = sr && (lvl > 0) && !flush;
    do_push = cs && wr && (a == 3'd1 || a == 3'd3);
    word    = {(a == 3'd3) ? byte_rev(wd) : wd, m_stage};
    if (pop_ok) void'(mq.pop_front());
    if (do_push) begin
      if (lvl < DEPTH || pop_ok) mq.push_back(word);
      else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (flush) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (cs && wr && a == 3'd0) m_stage = wd;
    if (cs && wr && a == 3'd2) m_stage = byte_rev(wd);
    @(posedge clk);
    #1;
    if (cs && rd) check_val("readdata", 64'(readdata), 64'(exp_rd));
    check_val("src_ready", 64'(src_ready), 64'(mq.size() == 0));
    if (mq.size() > 0) check_val("din", din, mq[0]);
    $display("txn a=%0d wd=%h wr=%0b rd=%0b cs=%0b sr=%0b q=%0d rdata=%h din=%h",
             a, wd, wr, rd, cs, sr, mq.size(), readdata, din);
  endtask

  task automatic push_word(input logic [31:0] lo, input logic [31:0] hi, input logic sw);
    txn(sw ? 3'd2 : 3'd0, lo, 1'b1, 1'b0, 1'b1, 1'b0);
    txn(sw ? 3'd3 : 3'd1, hi, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_flush();
    txn(3'd4, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    txn(a, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; writedata = '0; write = 0; read = 0; chipselect = 0; src_read = 0;
    model_reset();
    #1;
    check_val("rst_ready", 64'(src_ready), 64'd1);
    check_val("rst_din", din, 64'd0);
    check_val("rst_rdata", 64'(readdata), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Status right after reset
    rd_reg(3'd4);
    check_val("stat_reset", 64'(readdata), 64'h1);

    // Raw word assembly
    push_word(32'h11223344, 32'hAABBCCDD, 1'b0);
    check_val("din_raw", din, 64'hAABBCCDD11223344);
    check_val("ready_raw", 64'(src_ready), 64'd0);
    rd_reg(3'd4);
    check_val("stat_lvl1", 64'(readdata), 64'h100);
    rd_reg(3'd6);
    check_val("stage_raw", 64'(readdata), 64'h11223344);

    // Byte-swapped assembly
    do_flush();
    push_word(32'h01020304, 32'h05060708, 1'b1);
    check_val("din_swap", din, 64'h0807060504030201);

    // Overflow: nine pushes into eight slots
    do_flush();
    for (int i = 0; i < 9; i++) push_word($urandom, $urandom, 1'($urandom % 2));
    rd_reg(3'd4);
    check_val("stat_ovf", 64'(readdata), 64'h806);
    rd_reg(3'd5);
    check_val("drop_one", 64'(readdata), 64'h1);
    for (int i = 0; i < 8; i++) txn(3'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("drained", 64'(src_ready), 64'd1);
    txn(3'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);  // pop while empty is ignored

    // Push and pop together while full
    do_flush();
    for (int i = 0; i < 8; i++) push_word($urandom, $urandom, 1'b0);
    txn(3'd0, 32'hCAFE0001, 1'b1, 1'b0, 1'b1, 1'b0);
    txn(3'd1, 32'hBEEF0002, 1'b1, 1'b0, 1'b1, 1'b1);
    rd_reg(3'd4);
    check_val("stat_full_pp", 64'(readdata), 64'h802);
    rd_reg(3'd5);
    check_val("drop_none", 64'(readdata), 64'h0);

    // Flush overrides a same-cycle pop
    do_flush();
    for (int i = 0; i < 3; i++) push_word($urandom, $urandom, 1'b0);
    txn(3'd4, 32'h1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_val("flush_ready", 64'(src_ready), 64'd1);
    rd_reg(3'd4);
    check_val("stat_flushed", 64'(readdata), 64'h1);
    rd_reg(3'd5);
    check_val("drop_flushed", 64'(readdata), 64'h0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = ($urandom % 2 == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd4) wd[0] = ($urandom % 6 == 0);
      txn(a, wd, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 8 != 0), 1'($urandom % 4 == 0));
    end

    // Asynchronous reset in the middle of a burst
    do_flush();
    for (int i = 0; i < 3; i++) push_word($urandom, $urandom, 1'b0);
    rd_reg(3'd4);
    check_val("stat_lvl3", 64'(readdata), 64'h300);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_val("mid_rst_ready", 64'(src_ready), 64'd1);
    check_val("mid_rst_din", din, 64'd0);
    check_val("mid_rst_rdata", 64'(readdata), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_reg(3'd4);
    check_val("stat_after_rst", 64'(readdata), 64'h1);
    rd_reg(3'd6);
    check_val("stage_after_rst", 64'(readdata), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blake_src_fifo.md
# blake_src_fifo

Upstream feeder for the Blake hash core. It collects 32-bit Avalon-MM writes, assembles them into 64-bit message words, and buffers them in a small FIFO. The FIFO drives the core's source handshake (`src_ready` active-low / `src_read`), so software can burst a whole block without polling per word. It sits between the Avalon slave fabric and the `din`/`src_ready`/`src_read` pins of the hash core.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries of 64 bits; must be a power of two, ≥2.
- `AW`, 3 — log2(DEPTH); pointer width.

Ports:
- `clk`  in  1  — single clock.
- `reset_n`  in  1  — reset, asynchronous assert, active-low.
- `address`  in  3  — Avalon word address.
- `writedata`  in  32  — Avalon write data.
- `write`  in  1  — Avalon write strobe.
- `read`  in  1  — Avalon read strobe.
- `chipselect`  in  1  — Avalon select; qualifies read and write.
- `readdata`  out  32  — registered read data.
- `src_ready`  out  1  — low = FIFO head word valid on `din`.
- `src_read`  in  1  — core consumes head word this cycle.
- `din`  out  64  — FIFO head word.

## Operation
- Register map (writes and reads take effect only when `chipselect`=1):
  - 0: write stages low word raw.
  - 1: write high word raw and pushes {writedata, staged_low}.
  - 2: write stages low word byte-swapped ({[7:0],[15:8],[23:16],[31:24]}).
  - 3: write high word byte-swapped and pushes.
  - 4: read returns status: [0] empty, [1] full, [2] overflow (sticky), [15:8] level (zero-extended). Write with writedata[0]=1 flushes.
  - 5: read returns drop count, 16-bit saturating, zero-extended.
  - 6: read returns staged_low.
  - 7: read returns 0.
  - Reads of 0–3 return 0; writes to 5–7 are ignored.
- Push on full with no same-cycle pop:
  - word is dropped;
  - overflow is set;
  - drop count increments, saturating at 0xFFFF.
- Pop:
  - occurs when `src_read`=1 and not empty;
  - `src_read` while empty is ignored.
- Simultaneous push and pop:
  - both are accepted, including when full;
  - level is unchanged.
- Flush:
  - clears pointers, level, overflow and drop count;
  - overrides a same-cycle pop;
  - staged_low is preserved.
- Level is 0..DEPTH (AW+1 bits). Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `readdata`=0, `src_ready`=1, `din`=0;
  - level=0, pointers=0, overflow=0, drop count=0, staged_low=0;
  - storage cleared to 0.
- Push in cycle N:
  - level updates at N+1;
  - `src_ready` falls at N+1 if the FIFO was empty.
- `src_ready` and `din` come from registered state. `din` = mem[rd_ptr] and is valid whenever `src_ready`=0.
- Pop in cycle N:
  - rd_ptr advances at N+1 and the next word appears on `din`;
  - `src_ready` rises at N+1 if the FIFO becomes empty.
- Read latency is 1 cycle. Status reflects state before that cycle's write or pop.
- Reset asserted mid-operation clears all state immediately; words in flight are lost.

## Structure
- Package `blake_src_pkg`:
  - register address constants (ADDR_LO, ADDR_HI, ADDR_LO_SW, ADDR_HI_SW, ADDR_STAT, ADDR_DROP, ADDR_STAGE);
  - status bit positions;
  - `bswap32` function.
- Sub-module `blake_sync_fifo`:
  - parameterised DEPTH × 64 storage, pointers and level;
  - push/pop/flush inputs; empty/full/level/head outputs.
- The top level handles Avalon decode, staging, byte-swap, overflow and drop counting, and the read mux.

## Test plan
- Reset, then read address 4 → 0x00000001; `src_ready`=1, `din`=0.
- Write 0x11223344 to addr 0, then 0xAABBCCDD to addr 1 → next cycle `src_ready`=0, `din`=0xAABBCCDD11223344; status level=1.
- Write 0x01020304 to addr 2, then 0x05060708 to addr 3 → `din`=0x0807060504030201.
- Push 9 words with `src_read`=0 (DEPTH=8):
  - status reads 0x00000806 (level 8, full, overflow);
  - drop count=1;
  - then pulse `src_read` 8 times → words emerge in order and `src_ready` returns to 1 after the 8th.
- Fill to full, then push and assert `src_read` in the same cycle → level stays 8, drop count unchanged, head advances by one.
- With 3 words queued:
  - write 1 to addr 4 while `src_read`=1 → level 0, `src_ready`=1, drop count 0;
  - assert `reset_n`=0 mid-burst → all outputs return to reset values without waiting for a clock edge.
